deserializer: RTL and testbench
===============================

Name: deserializer

Overview:
- Receive-side counterpart of the team's LSB-first serializer: collects WIDTH serial bits into a parallel word.
- Sits in the serial receive path, behind the receive control FSM. That FSM pulses Start at frame begin and Enable once per data bit at its sample point.
- Presents the completed word on P_DATA with a one-cycle Data_Valid pulse, and reports Busy while a word is being assembled.

Parameters:
- WIDTH, 8, data word width in bits. Legal range is WIDTH >= 2; non-power-of-two values are legal.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- ser_in  input  1  sampled serial data bit, valid whenever Enable=1.
- Start  input  1  single-cycle pulse that begins a new word.
- Enable  input  1  single-cycle strobe meaning "ser_in holds the next bit".
- Abort  input  1  synchronous cancel, e.g. on framing or glitch detection.
- P_DATA  output  WIDTH  last completed word, registered.
- Data_Valid  output  1  one-cycle pulse when P_DATA is updated.
- Busy  output  1  high while assembling a word.

Behaviour:
- Reset (RST=1, asynchronous): state=IDLE, shift_reg=0, bit_cnt=0, P_DATA=0, Data_Valid=0, Busy=0.
- bit_cnt width is $clog2(WIDTH). It counts 0..WIDTH-1 and never wraps past WIDTH-1 within a word.
- FSM states: IDLE, SHIFT.
- Busy = (state==SHIFT), decoded from the state register, so there is no glitch on the output.
- In IDLE:
  - Enable is ignored and ser_in is don't-care.
  - Start=1 -> shift_reg<=0, bit_cnt<=0, next state SHIFT.
- In SHIFT, on Enable=1:
  - shift_reg <= {ser_in, shift_reg[WIDTH-1:1]} (LSB-first, so the first bit received ends up in bit 0).
  - bit_cnt <= bit_cnt+1.
- In SHIFT, on Enable=1 with bit_cnt==WIDTH-1 (last bit):
  - P_DATA <= {ser_in, shift_reg[WIDTH-1:1]}.
  - Data_Valid <= 1.
  - bit_cnt <= 0, next state IDLE.
- In SHIFT, Enable=0: hold all state; no timeout inside this block.
- Latency: Data_Valid is high in the cycle after the clock edge that samples the WIDTH-th Enable. P_DATA carries the new word in that same cycle.
- Data_Valid is high for exactly one cycle per completed word.
- P_DATA holds its value until the next completion. Start and Abort do not clear it.
- Priority, highest first: RST > Abort > Start > Enable.
  - Abort=1 in any state -> IDLE, bit_cnt<=0, no Data_Valid, P_DATA unchanged. Any simultaneous Start or Enable is ignored.
  - Start=1 while in SHIFT -> restart: shift_reg<=0, bit_cnt<=0, stay in SHIFT. A simultaneous Enable bit is discarded.
  - Start=1 in the same cycle as the final Enable -> restart wins; no Data_Valid.
- Start may arrive in the cycle Data_Valid is high. The new word begins normally and P_DATA stays stable.
- Reset asserted mid-word: everything clears immediately, and no Data_Valid is issued after release.
- No combinational path from inputs to outputs.

Test Plan:
- Basic 0xA5: Start, then 8 Enables with ser_in=1,0,1,0,0,1,0,1 (Enable gaps of 0 and 3 idle cycles mixed) -> exactly one Data_Valid pulse, P_DATA=0xA5, Busy high from the cycle after Start until the cycle after the 8th Enable.
- Back-to-back words: 0x3C then 0xFF, with Start issued in the Data_Valid cycle -> two pulses, P_DATA=0x3C then 0xFF, and P_DATA is never corrupted between them.
- Abort after 5 bits of 0x81 -> Busy falls, no Data_Valid, P_DATA retains its previous value (0x00 after reset). A following full word 0x55 is then received correctly.
- Restart: Start, 3 bits, Start again, then 8 bits of 0x0F -> a single Data_Valid pulse with P_DATA=0x0F. Also drive Start coincident with the 8th Enable -> no pulse.
- Async reset asserted after 4 bits and between clock edges -> outputs go to 0 immediately. Enables in IDLE with no Start -> no state change.
- WIDTH=5 instance: bits 1,1,0,0,1 -> P_DATA=5'b10011. Data_Valid occurs only after the 5th Enable, and bit_cnt never exceeds 4.

Source files
------------

// File: rtl/deserializer.sv
// LSB-first serial-to-parallel receiver: collects WIDTH bits strobed by Enable
// and presents the completed word on P_DATA with a one-cycle Data_Valid pulse.
module deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ser_in,
  input  logic             Start,
  input  logic             Enable,
  input  logic             Abort,
  output logic [WIDTH-1:0] P_DATA,
  output logic             Data_Valid,
  output logic             Busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] bit_cnt;

  assign Busy = (state == SHIFT);

  // Abort outranks Start, which outranks the Enable strobe.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
    end else begin
      Data_Valid <= 1'b0;
      if (Abort) begin
        state   <= IDLE;
        bit_cnt <= '0;
      end else if (Start) begin
        shift_reg <= '0;
        bit_cnt   <= '0;
        state     <= SHIFT;
      end else if (state == SHIFT && Enable) begin
        shift_reg <= {ser_in, shift_reg[WIDTH-1:1]};
        if (bit_cnt == LAST) begin
          P_DATA     <= {ser_in, shift_reg[WIDTH-1:1]};
          Data_Valid <= 1'b1;
          bit_cnt    <= '0;
          state      <= IDLE;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Directed, table-driven bench for deserializer (WIDTH=8) plus hand sequences
// for async reset and a WIDTH=5 instance.
module tb_deserializer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       ser_in, Start, Enable, Abort;
  logic [7:0] P_DATA;
  logic       Data_Valid, Busy;

  logic       s5_ser, s5_start, s5_en, s5_abort;
  logic [4:0] P5;
  logic       dv5, busy5;

  always #5 CLK = ~CLK;

  deserializer #(.WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .ser_in(ser_in), .Start(Start), .Enable(Enable),
    .Abort(Abort), .P_DATA(P_DATA), .Data_Valid(Data_Valid), .Busy(Busy)
  );

  deserializer #(.WIDTH(5)) dut5 (
    .CLK(CLK), .RST(RST), .ser_in(s5_ser), .Start(s5_start), .Enable(s5_en),
    .Abort(s5_abort), .P_DATA(P5), .Data_Valid(dv5), .Busy(busy5)
  );

  typedef struct {
    logic       st, en, ab, si;
    logic       dv, busy;
    logic [7:0] pd;
  } vec_t;

  vec_t        vecs[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic add(input logic st, en, ab, si, dv, busy, input logic [7:0] pd);
    vec_t v;
    v.st = st; v.en = en; v.ab = ab; v.si = si;
    v.dv = dv; v.busy = busy; v.pd = pd;
    vecs.push_back(v);
  endtask

  // Full word after a Start; optional 3-cycle idle gap after bit i when gap[i]=1.
  task automatic add_word(input logic [7:0] w, input logic [7:0] prev, input logic [7:0] gap);
    for (int i = 0; i < 8; i++) begin
      add(1'b0, 1'b1, 1'b0, w[i], (i == 7), (i != 7), (i == 7) ? w : prev);
      if (i < 7 && gap[i])
        repeat (3) add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, prev);
    end
  endtask

  task automatic add_partial(input logic [7:0] w, input int n, input logic [7:0] prev);
    for (int i = 0; i < n; i++)
      add(1'b0, 1'b1, 1'b0, w[i], 1'b0, 1'b1, prev);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    {ser_in, Start, Enable, Abort} = '0;
    {s5_ser, s5_start, s5_en, s5_abort} = '0;

    // Abort after 5 bits of 0x81 (Enable also high, must be ignored), then 0x55
    add(1, 0, 0, 0, 0, 1, 8'h00);
    add_partial(8'h81, 5, 8'h00);
    add(0, 1, 1, 1, 0, 0, 8'h00);
    add(0, 0, 0, 0, 0, 0, 8'h00);
    add(1, 0, 0, 0, 0, 1, 8'h00);
    add_word(8'h55, 8'h00, 8'h00);
    add(0, 0, 0, 0, 0, 0, 8'h55);
    // 0xA5 with idle gaps after bits 2 and 5, then an Enable in IDLE
    add(1, 0, 0, 0, 0, 1, 8'h55);
    add_word(8'hA5, 8'h55, 8'b0010_0100);
    add(0, 0, 0, 0, 0, 0, 8'hA5);
    add(0, 1, 0, 1, 0, 0, 8'hA5);
    // Back-to-back 0x3C then 0xFF, second Start in the Data_Valid cycle
    add(1, 0, 0, 0, 0, 1, 8'hA5);
    add_word(8'h3C, 8'hA5, 8'h00);
    add(1, 0, 0, 0, 0, 1, 8'h3C);
    add_word(8'hFF, 8'h3C, 8'h00);
    add(0, 0, 0, 0, 0, 0, 8'hFF);
    // Restart after 3 bits (restart Start carries a discarded Enable bit), then 0x0F
    add(1, 0, 0, 0, 0, 1, 8'hFF);
    add_partial(8'h07, 3, 8'hFF);
    add(1, 1, 0, 1, 0, 1, 8'hFF);
    add_word(8'h0F, 8'hFF, 8'h00);
    // Start coincident with the 8th Enable: no pulse, new word 0x96 follows
    add(1, 0, 0, 0, 0, 1, 8'h0F);
    add_partial(8'hFF, 7, 8'h0F);
    add(1, 1, 0, 1, 0, 1, 8'h0F);
    add_word(8'h96, 8'h0F, 8'h00);
    add(0, 0, 0, 0, 0, 0, 8'h96);

    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    chk("reset P_DATA", P_DATA, 8'h00);
    chk("reset Data_Valid", Data_Valid, 1'b0);
    chk("reset Busy", Busy, 1'b0);
    chk("reset w5 P_DATA", P5, 5'h00);

    foreach (vecs[i]) begin
      Start = vecs[i].st; Enable = vecs[i].en; Abort = vecs[i].ab; ser_in = vecs[i].si;
      tick();
      chk($sformatf("row%0d Data_Valid", i), Data_Valid, vecs[i].dv);
      chk($sformatf("row%0d Busy", i), Busy, vecs[i].busy);
      chk($sformatf("row%0d P_DATA", i), P_DATA, vecs[i].pd);
    end
    {ser_in, Start, Enable, Abort} = '0;

    // Async reset between edges after 4 bits
    Start = 1'b1;
    tick();
    Start = 1'b0;
    Enable = 1'b1; ser_in = 1'b1;
    repeat (4) tick();
    Enable = 1'b0;
    chk("pre-reset Busy", Busy, 1'b1);
    chk("pre-reset P_DATA", P_DATA, 8'h96);
    #3 RST = 1'b1;
    #1;
    chk("async P_DATA", P_DATA, 8'h00);
    chk("async Busy", Busy, 1'b0);
    chk("async Data_Valid", Data_Valid, 1'b0);
    tick();
    RST = 1'b0;
    // Enables in IDLE with no Start: nothing moves, no stale completion
    Enable = 1'b1; ser_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("idle%0d Busy", i), Busy, 1'b0);
      chk($sformatf("idle%0d Data_Valid", i), Data_Valid, 1'b0);
      chk($sformatf("idle%0d P_DATA", i), P_DATA, 8'h00);
    end
    Enable = 1'b0;

    // WIDTH=5: bits 1,1,0,0,1 -> 5'b10011
    begin
      logic [4:0] b5;
      b5 = 5'b10011;
      s5_start = 1'b1;
      tick();
      s5_start = 1'b0;
      chk("w5 Busy after Start", busy5, 1'b1);
      for (int i = 0; i < 5; i++) begin
        s5_en = 1'b1; s5_ser = b5[i];
        tick();
        chk($sformatf("w5 bit%0d Data_Valid", i), dv5, (i == 4));
        chk($sformatf("w5 bit%0d cnt<=4", i), (dut5.bit_cnt <= 3'd4), 1'b1);
      end
      s5_en = 1'b0;
      chk("w5 P_DATA", P5, 5'b10011);
      chk("w5 Busy done", busy5, 1'b0);
      tick();
      chk("w5 Data_Valid one-shot", dv5, 1'b0);
      chk("w5 P_DATA hold", P5, 5'b10011);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
